fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of instructionmemory. It owns the program counter and drives the memory read address. It pairs each synchronous-read result with its PC and presents a valid-tagged instruction to decode. It handles stall, branch redirect and debug-load halt. While enable_debug is high it idles, so the debug port can own the memory.

Parameters:
INS_ADDRESS, 9, width of instruction-memory address (byte address, low bits of PC)
INS_W, 32, instruction width
RESET_PC, 32'h0000_0000, PC loaded on reset and on debug exit
NOP_INST, 32'h0000_0013, instruction emitted on bubbles

Ports:
clk  in  1  single clock, all state rising-edge
reset  in  1  synchronous, active-high
enable_debug  in  1  debug-load mode; fetch halted, same signal as the memory's debug enable
stall  in  1  downstream cannot accept; hold current output
redirect_valid  in  1  branch/jump taken, change PC
redirect_target  in  32  new PC (byte address)
imem_rdata  in  INS_W  instruction from memory, valid one cycle after address sampled
imem_addr  out  INS_ADDRESS  read address to memory (raddress)
if_pc  out  32  PC of instruction on if_inst
if_inst  out  INS_W  fetched instruction, NOP_INST when if_valid=0
if_valid  out  1  if_inst/if_pc carry a real instruction
fetch_count  out  32  count of instructions accepted downstream

Behaviour:
- State: pc_q (next PC to fetch), req_pc_q (PC in flight), req_valid_q, fsm {HALT, RUN}, fetch_count.
- Reset values: pc_q=RESET_PC, req_pc_q=RESET_PC, req_valid_q=0, fsm=HALT, fetch_count=0.
- Outputs under reset: if_valid=0, if_inst=NOP_INST, if_pc=RESET_PC, imem_addr=RESET_PC[INS_ADDRESS-1:0].
- Memory is synchronous read. The address presented in cycle n is sampled at the n/n+1 edge, and imem_rdata is valid in cycle n+1.
- imem_addr = (stall && req_valid_q && fsm==RUN) ? req_pc_q[INS_ADDRESS-1:0] : pc_q[INS_ADDRESS-1:0]. Stall replays the in-flight address, so the memory output stays constant.
- if_pc = req_pc_q; if_valid = req_valid_q; if_inst = req_valid_q ? imem_rdata : NOP_INST.
- Priority per edge: reset > enable_debug > redirect_valid > stall > advance.
- enable_debug=1 (any state):
  - fsm<=HALT, pc_q<=RESET_PC, req_valid_q<=0.
  - Holds for the whole debug window.
- HALT with enable_debug=0 acts as the first fetch:
  - pc_q<=RESET_PC+4, req_pc_q<=RESET_PC, req_valid_q<=1, fsm<=RUN.
  - The first valid instruction appears 2 cycles after reset/debug deassertion.
- RUN, redirect_valid=1 (stall ignored):
  - pc_q<={redirect_target[31:2],2'b00}, req_valid_q<=0.
  - Exactly one bubble follows; the target's instruction is output in the cycle after the bubble.
  - Squashing the wrong-path instruction present in the redirect cycle is the consumer's job.
- RUN, stall=1: all state held; output stable for the full stall duration.
- RUN advance: req_pc_q<=pc_q, pc_q<=pc_q+4, req_valid_q<=1.
- Arithmetic:
  - PC adds are 32-bit modulo 2^32.
  - imem_addr truncates to INS_ADDRESS bits, so memory aliasing wraps naturally.
  - if_pc keeps the full 32 bits.
- redirect_target[1:0] is always forced to 00.
- fetch_count: +1 on edges where if_valid=1 && stall=0 && enable_debug=0. Cleared only by reset; wraps modulo 2^32.
- Reset mid-stall or mid-redirect: reset wins; fetch restarts from RESET_PC exactly as at power-up.
- Stall while req_valid_q=0: bubble held, pc_q not advanced.

Test Plan:
- Reset 2 cycles, enable_debug=0; mem[0]=0x11111111, mem[4]=0x22222222, mem[8]=0x33333333 -> cycle 1 after release if_valid=0, if_inst=0x13; cycle 2 if_pc=0 inst=0x11111111; cycle 3 if_pc=4 inst=0x22222222; fetch_count=2 after cycle 3.
- Stall high 3 cycles while if_pc=8 -> if_pc=8, if_inst=0x33333333, imem_addr=8 held; fetch_count frozen; first cycle after release if_pc=0xC.
- redirect_valid with target 0x40 while if_pc=0x10 -> next cycle if_valid=0, if_inst=0x13; cycle after that if_pc=0x40 with mem[0x40].
- redirect_valid and stall together, target 0x103 -> redirect wins; bubble, then if_pc=0x100.
- enable_debug high 5 cycles mid-run -> if_valid=0 throughout, fetch_count unchanged; 2 cycles after deassert if_pc=0 with freshly loaded mem[0].
- INS_ADDRESS=9, redirect to 0x1FC -> if_pc 0x1FC then 0x200; imem_addr for 0x200 = 0x000 and if_inst=mem[0].

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction memory
// and pairs each returned word with its PC for decode.
module fetch_unit #(
  parameter int unsigned      INS_ADDRESS = 9,
  parameter int unsigned      INS_W       = 32,
  parameter logic [31:0]      RESET_PC    = 32'h0000_0000,
  parameter logic [INS_W-1:0] NOP_INST    = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable_debug,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_target,
  input  logic [INS_W-1:0]       imem_rdata,
  output logic [INS_ADDRESS-1:0] imem_addr,
  output logic [31:0]            if_pc,
  output logic [INS_W-1:0]       if_inst,
  output logic                   if_valid,
  output logic [31:0]            fetch_count
);

  typedef enum logic {HALT, RUN} fsm_t;

  fsm_t        fsm_q, fsm_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] fetch_count_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q <= HALT;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      req_pc_q    <= RESET_PC;
      req_valid_q <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
      fetch_count <= fetch_count_d;
    end
  end

  // Debug outranks everything; HALT exits by issuing the RESET_PC fetch itself.
  always_comb begin
    fsm_d       = fsm_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    req_valid_d = req_valid_q;
    if (enable_debug) begin
      fsm_d       = HALT;
      pc_d        = RESET_PC;
      req_valid_d = 1'b0;
    end else if (fsm_q == HALT) begin
      fsm_d       = RUN;
      pc_d        = RESET_PC + 32'd4;
      req_pc_d    = RESET_PC;
      req_valid_d = 1'b1;
    end else if (redirect_valid) begin
      pc_d        = redirect_target & 32'hFFFF_FFFC;
      req_valid_d = 1'b0;
    end else if (!stall) begin
      req_pc_d    = pc_q;
      pc_d        = pc_q + 32'd4;
      req_valid_d = 1'b1;
    end
  end

  always_comb begin
    fetch_count_d = fetch_count;
    if (req_valid_q && !stall && !enable_debug) begin
      fetch_count_d = fetch_count + 32'd1;
    end
  end

  // Stall re-presents the in-flight address so the memory output stays put.
  always_comb begin
    if (stall && req_valid_q && (fsm_q == RUN)) begin
      imem_addr = req_pc_q[INS_ADDRESS-1:0];
    end else begin
      imem_addr = pc_q[INS_ADDRESS-1:0];
    end
    if_pc    = req_pc_q;
    if_valid = req_valid_q;
    if_inst  = req_valid_q ? imem_rdata : NOP_INST;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 512-byte synchronous-read memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable_debug;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_rdata;
  logic [8:0]  imem_addr;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:127];
  int          checks = 0;
  int          errors = 0;

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .enable_debug    (enable_debug),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_rdata      (imem_rdata),
    .imem_addr       (imem_addr),
    .if_pc           (if_pc),
    .if_inst         (if_inst),
    .if_valid        (if_valid),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= mem[imem_addr[8:2]];

  task automatic applyStimulus(input logic dbg, input logic stl, input logic rv,
                               input logic [31:0] tgt);
    enable_debug    = dbg;
    stall           = stl;
    redirect_valid  = rv;
    redirect_target = tgt;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkFetch(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] inst);
    checkOutput({tag, "_valid"}, {31'd0, if_valid}, {31'd0, v});
    checkOutput({tag, "_inst"}, if_inst, inst);
    if (v) checkOutput({tag, "_pc"}, if_pc, pc);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'hA500_0000 + 32'(i * 4);
    mem[0]   = 32'h1111_1111;
    mem[1]   = 32'h2222_2222;
    mem[2]   = 32'h3333_3333;
    mem[3]   = 32'h4444_4444;
    mem[4]   = 32'h5555_5555;
    mem[16]  = 32'h4040_4040;
    mem[64]  = 32'h0100_0100;
    mem[127] = 32'h1FC1_FC1F;

    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    checkFetch("rst", 1'b0, 32'd0, 32'h13);
    checkOutput("rst_pc", if_pc, 32'd0);
    checkOutput("rst_addr", {23'd0, imem_addr}, 32'd0);
    checkOutput("rst_count", fetch_count, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    checkFetch("boot_c1", 1'b0, 32'd0, 32'h13);
    @(negedge clk);
    checkFetch("boot_c2", 1'b1, 32'h0, 32'h1111_1111);
    @(negedge clk);
    checkFetch("boot_c3", 1'b1, 32'h4, 32'h2222_2222);
    @(negedge clk);
    checkFetch("run_8", 1'b1, 32'h8, 32'h3333_3333);
    checkOutput("count_2", fetch_count, 32'd2);

    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkFetch("stall", 1'b1, 32'h8, 32'h3333_3333);
      checkOutput("stall_addr", {23'd0, imem_addr}, 32'h8);
      checkOutput("stall_count", fetch_count, 32'd2);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    checkFetch("unstall", 1'b1, 32'hC, 32'h4444_4444);
    checkOutput("unstall_count", fetch_count, 32'd3);
    @(negedge clk);
    checkFetch("run_10", 1'b1, 32'h10, 32'h5555_5555);

    applyStimulus(1'b0, 1'b0, 1'b1, 32'h40);
    @(negedge clk);
    checkFetch("redir_bubble", 1'b0, 32'd0, 32'h13);
    checkOutput("redir_addr", {23'd0, imem_addr}, 32'h40);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    checkFetch("redir_tgt", 1'b1, 32'h40, 32'h4040_4040);
    checkOutput("redir_count", fetch_count, 32'd5);

    applyStimulus(1'b0, 1'b1, 1'b1, 32'h103);
    @(negedge clk);
    checkFetch("rs_bubble", 1'b0, 32'd0, 32'h13);
    checkOutput("rs_addr", {23'd0, imem_addr}, 32'h100);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    checkFetch("rs_tgt", 1'b1, 32'h100, 32'h0100_0100);
    checkOutput("rs_count", fetch_count, 32'd5);

    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    mem[0] = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkFetch("dbg", 1'b0, 32'd0, 32'h13);
      checkOutput("dbg_count", fetch_count, 32'd5);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    checkFetch("dbg_exit", 1'b1, 32'h0, 32'hDEAD_BEEF);
    checkOutput("dbg_exit_count", fetch_count, 32'd5);

    applyStimulus(1'b0, 1'b0, 1'b1, 32'h1FC);
    @(negedge clk);
    checkFetch("wrap_bubble", 1'b0, 32'd0, 32'h13);
    checkOutput("wrap_addr_1fc", {23'd0, imem_addr}, 32'h1FC);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    checkFetch("wrap_1fc", 1'b1, 32'h1FC, 32'h1FC1_FC1F);
    checkOutput("wrap_addr_200", {23'd0, imem_addr}, 32'h000);
    @(negedge clk);
    checkFetch("wrap_200", 1'b1, 32'h200, 32'hDEAD_BEEF);
    checkOutput("wrap_count", fetch_count, 32'd7);

    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    checkFetch("rst_mid", 1'b0, 32'd0, 32'h13);
    checkOutput("rst_mid_pc", if_pc, 32'd0);
    checkOutput("rst_mid_addr", {23'd0, imem_addr}, 32'd0);
    checkOutput("rst_mid_count", fetch_count, 32'd0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    checkFetch("restart", 1'b1, 32'h0, 32'hDEAD_BEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
